body_integrator: RTL and testbench
==================================

BODY_INTEGRATOR -- requirements
Module: body_integrator

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 16, meaning the width of position and velocity words (signed Q1.15).
REQ-002 SHALL have parameter ACC_WIDTH, default 28, meaning the width of accumulated force words (signed Q13.15).
REQ-003 SHALL have parameter N_BODIES, default 16, meaning the number of bodies per time step.
REQ-004 SHALL have parameter DT_SHIFT, default 4, meaning the time step dt = 2^-DT_SHIFT.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-007 SHALL have port load_en, input, 1 bit: initial-state write strobe.
REQ-008 SHALL have port load_idx, input, $clog2(N_BODIES) bits: body index for the write.
REQ-009 SHALL have ports load_x, load_y, load_vx, load_vy, input, DATA_WIDTH bits each: initial position and velocity.
REQ-010 SHALL have port step_start, input, 1 bit: single-cycle pulse that begins one time step.
REQ-011 SHALL have ports acc_in_valid (input, 1), acc_in_ready (output, 1), acc_in_x and acc_in_y (input, ACC_WIDTH each): net-force stream, bodies in index order 0..N_BODIES-1.
REQ-012 SHALL have ports pos_valid (output, 1), pos_ready (input, 1), pos_idx (output, $clog2(N_BODIES)), pos_x and pos_y (output, DATA_WIDTH each): updated-position stream.
REQ-013 SHALL have outputs busy (1 bit, high in RUN or DRAIN) and step_done (1 bit, single-cycle pulse).

Function
REQ-014 SHALL implement the states IDLE, RUN and DRAIN, and SHALL enter IDLE on reset.
REQ-015 In IDLE only, load_en SHALL write the four load words to body load_idx at the clock edge; load_en in RUN or DRAIN SHALL be ignored.
REQ-016 step_start in IDLE SHALL move the block to RUN and clear the body counter to 0; step_start outside IDLE SHALL be ignored.
REQ-017 acc_in_ready SHALL be 0 outside RUN; in RUN it SHALL equal (!pos_valid || pos_ready).
REQ-018 A transfer SHALL occur when acc_in_valid and acc_in_ready are both high; each transfer applies to the body given by the counter, and the counter SHALL then increment.
REQ-019 Per transfer, velocity SHALL update as v' = sat(v + (acc >>> DT_SHIFT)), using an arithmetic shift (floor), ACC_WIDTH+1-bit intermediate, and saturation to [-32768, 32767].
REQ-020 Position SHALL update semi-implicitly as p' = sat(p + (v' >>> DT_SHIFT)), with the same shift and saturation rules; x and y SHALL be handled independently.
REQ-021 v' and p' SHALL be written back at the transfer edge; in the same edge pos_valid SHALL be set and pos_idx, pos_x and pos_y SHALL be loaded, giving 1-cycle latency.
REQ-022 While pos_valid is 1 and pos_ready is 0, pos_idx, pos_x and pos_y SHALL hold stable; pos_valid SHALL clear on a pos handshake unless a new transfer occurs in the same cycle.
REQ-023 The transfer for body N_BODIES-1 SHALL move the block to DRAIN; no further transfers SHALL be accepted in DRAIN.
REQ-024 In DRAIN, when the final pos handshake completes, step_done SHALL pulse for one cycle and the block SHALL return to IDLE.
REQ-025 step_done SHALL fire exactly once per step, and SHALL NOT fire in the same cycle that step_start is sampled.

Reset
REQ-026 Reset SHALL set all body state to 0, the state to IDLE and the counter to 0, and SHALL clear pos_valid, pos_idx, pos_x, pos_y, busy and step_done to 0.
REQ-027 Reset asserted mid-step SHALL abandon the step immediately, with no step_done pulse; acc_in_ready SHALL read 0 while reset is high.

Structure
REQ-028 Shared package nbody_pkg SHALL hold DATA_WIDTH, ACC_WIDTH, the Q-format fraction-bit constant (15), the integrator state enum, and the saturate-to-DATA_WIDTH function.
REQ-029 Combinational sub-module body_update_calc SHALL compute (v', p') from (v, p, acc) for one axis and SHALL be instantiated twice, once for x and once for y.
REQ-030 Body state SHALL be held in register arrays of N_BODIES entries.

Verification (DT_SHIFT=4)
REQ-031 Basic update: load body0 with p=0 and v=0, step, acc_x=4096 -> pos_x=16, stored vx=256, pos_idx=0 one cycle after the transfer.
REQ-032 Floor and saturation: acc_x=-1 with v=0 and p=0 -> vx=-1 and pos_x=-1; acc_x=8000 with vx=32700 -> vx=32767, and with px=32760 -> pos_x=32767.
REQ-033 Backpressure: hold pos_ready=0 for 5 cycles -> acc_in_ready=0 and pos outputs stable; releasing pos_ready allows exactly one new transfer per cycle with no loss or duplication.
REQ-034 Full step: run 16 bodies with random gaps in valid and ready -> pos_idx runs 0..15 in order, step_done pulses once after the idx-15 handshake, and busy falls in the same cycle.
REQ-035 Ignored controls: step_start and load_en pulsed during RUN -> no state change and no memory change.
REQ-036 Reset after 7 bodies -> outputs 0, state IDLE, no step_done; a new load and step then behave as REQ-031.

Source files
------------

// File: rtl/nbody_pkg.sv
// Shared widths, integrator state encoding and the saturating narrow
// used by the body integrator datapath.
package nbody_pkg;

    localparam int FRAC_BITS  = 15;
    localparam int DATA_WIDTH = FRAC_BITS + 1;   // Q1.15
    localparam int ACC_WIDTH  = FRAC_BITS + 13;  // Q13.15

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } integ_state_t;

    localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((2 ** (DATA_WIDTH-1)) - 1);
    localparam logic signed [ACC_WIDTH:0] SAT_MIN = (ACC_WIDTH+1)'(-(2 ** (DATA_WIDTH-1)));

    function automatic logic signed [DATA_WIDTH-1:0] sat_data(input logic signed [ACC_WIDTH:0] val);
        if (val > SAT_MAX) begin
            sat_data = SAT_MAX[DATA_WIDTH-1:0];
        end else if (val < SAT_MIN) begin
            sat_data = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            sat_data = val[DATA_WIDTH-1:0];
        end
    endfunction

endpackage

// File: rtl/body_update_calc.sv
// One-axis semi-implicit Euler step: v' = sat(v + acc*dt), p' = sat(p + v'*dt),
// with dt = 2^-DT_SHIFT applied as a flooring arithmetic shift.
module body_update_calc
    import nbody_pkg::*;
#(
    parameter int DT_SHIFT = 4
) (
    input  logic signed [DATA_WIDTH-1:0] v,
    input  logic signed [DATA_WIDTH-1:0] p,
    input  logic signed [ACC_WIDTH-1:0]  acc,
    output logic signed [DATA_WIDTH-1:0] v_next,
    output logic signed [DATA_WIDTH-1:0] p_next
);

    logic signed [ACC_WIDTH:0] v_sum;
    logic signed [ACC_WIDTH:0] p_sum;

    always_comb begin
        v_sum  = (ACC_WIDTH+1)'(v) + (ACC_WIDTH+1)'(acc >>> DT_SHIFT);
        v_next = sat_data(v_sum);
        // Position uses the freshly updated velocity (semi-implicit).
        p_sum  = (ACC_WIDTH+1)'(p) + (ACC_WIDTH+1)'(v_next >>> DT_SHIFT);
        p_next = sat_data(p_sum);
    end

endmodule

// File: rtl/body_integrator.sv
// Per-time-step body integrator: consumes one net-force word per body in index
// order, updates stored velocity/position and streams the new position out.
module body_integrator
    import nbody_pkg::*;
#(
    parameter int DATA_WIDTH = nbody_pkg::DATA_WIDTH,
    parameter int ACC_WIDTH  = nbody_pkg::ACC_WIDTH,
    parameter int N_BODIES   = 16,
    parameter int DT_SHIFT   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load_en,
    input  logic [$clog2(N_BODIES)-1:0] load_idx,
    input  logic [DATA_WIDTH-1:0]       load_x,
    input  logic [DATA_WIDTH-1:0]       load_y,
    input  logic [DATA_WIDTH-1:0]       load_vx,
    input  logic [DATA_WIDTH-1:0]       load_vy,
    input  logic                        step_start,
    input  logic                        acc_in_valid,
    output logic                        acc_in_ready,
    input  logic [ACC_WIDTH-1:0]        acc_in_x,
    input  logic [ACC_WIDTH-1:0]        acc_in_y,
    output logic                        pos_valid,
    input  logic                        pos_ready,
    output logic [$clog2(N_BODIES)-1:0] pos_idx,
    output logic [DATA_WIDTH-1:0]       pos_x,
    output logic [DATA_WIDTH-1:0]       pos_y,
    output logic                        busy,
    output logic                        step_done
);

    localparam int IDX_W = $clog2(N_BODIES);

    integ_state_t                  state;
    logic [IDX_W-1:0]              cnt;
    logic signed [DATA_WIDTH-1:0]  px_mem [N_BODIES];
    logic signed [DATA_WIDTH-1:0]  py_mem [N_BODIES];
    logic signed [DATA_WIDTH-1:0]  vx_mem [N_BODIES];
    logic signed [DATA_WIDTH-1:0]  vy_mem [N_BODIES];

    logic                          xfer;
    logic                          pos_hs;
    logic signed [DATA_WIDTH-1:0]  vx_next, px_next, vy_next, py_next;

    // A new position may be produced whenever the output slot is free or emptying.
    assign acc_in_ready = (state == ST_RUN) && (!pos_valid || pos_ready);
    assign xfer         = acc_in_valid && acc_in_ready;
    assign pos_hs       = pos_valid && pos_ready;
    assign busy         = (state != ST_IDLE);

    body_update_calc #(.DT_SHIFT(DT_SHIFT)) u_calc_x (
        .v      (vx_mem[cnt]),
        .p      (px_mem[cnt]),
        .acc    (acc_in_x),
        .v_next (vx_next),
        .p_next (px_next)
    );

    body_update_calc #(.DT_SHIFT(DT_SHIFT)) u_calc_y (
        .v      (vy_mem[cnt]),
        .p      (py_mem[cnt]),
        .acc    (acc_in_y),
        .v_next (vy_next),
        .p_next (py_next)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            pos_valid <= 1'b0;
            pos_idx   <= '0;
            pos_x     <= '0;
            pos_y     <= '0;
            step_done <= 1'b0;
            // NOTE: body state is architecturally zero after reset, so the
            // arrays are cleared here rather than left to power-up contents.
            for (int i = 0; i < N_BODIES; i++) begin
                px_mem[i] <= '0;
                py_mem[i] <= '0;
                vx_mem[i] <= '0;
                vy_mem[i] <= '0;
            end
        end else begin
            step_done <= (state == ST_DRAIN) && pos_hs;

            case (state)
                ST_IDLE: begin
                    if (load_en) begin
                        px_mem[load_idx] <= load_x;
                        py_mem[load_idx] <= load_y;
                        vx_mem[load_idx] <= load_vx;
                        vy_mem[load_idx] <= load_vy;
                    end
                    if (step_start) begin
                        state <= ST_RUN;
                        cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    if (xfer) begin
                        vx_mem[cnt] <= vx_next;
                        px_mem[cnt] <= px_next;
                        vy_mem[cnt] <= vy_next;
                        py_mem[cnt] <= py_next;
                        cnt         <= cnt + IDX_W'(1);
                        if (cnt == IDX_W'(N_BODIES - 1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (pos_hs) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // A transfer refills the output slot in the same edge it drains.
            if (xfer) begin
                pos_valid <= 1'b1;
                pos_idx   <= cnt;
                pos_x     <= px_next;
                pos_y     <= py_next;
            end else if (pos_ready) begin
                pos_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_body_integrator.sv
// Randomized bench for body_integrator against an arithmetic model of the
// per-body Euler update, with a scoreboard on the position stream.
module tb_body_integrator;

    localparam int DW  = 16;
    localparam int AW  = 28;
    localparam int NB  = 16;
    localparam int DTS = 4;
    localparam int IW  = $clog2(NB);

    logic          clk = 1'b0;
    logic          rst;
    logic          load_en;
    logic [IW-1:0] load_idx;
    logic [DW-1:0] load_x, load_y, load_vx, load_vy;
    logic          step_start;
    logic          acc_in_valid;
    logic          acc_in_ready;
    logic [AW-1:0] acc_in_x, acc_in_y;
    logic          pos_valid;
    logic          pos_ready;
    logic [IW-1:0] pos_idx;
    logic [DW-1:0] pos_x, pos_y;
    logic          busy;
    logic          step_done;

    always #5 clk = ~clk;

    body_integrator #(
        .DATA_WIDTH (DW),
        .ACC_WIDTH  (AW),
        .N_BODIES   (NB),
        .DT_SHIFT   (DTS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .load_en      (load_en),
        .load_idx     (load_idx),
        .load_x       (load_x),
        .load_y       (load_y),
        .load_vx      (load_vx),
        .load_vy      (load_vy),
        .step_start   (step_start),
        .acc_in_valid (acc_in_valid),
        .acc_in_ready (acc_in_ready),
        .acc_in_x     (acc_in_x),
        .acc_in_y     (acc_in_y),
        .pos_valid    (pos_valid),
        .pos_ready    (pos_ready),
        .pos_idx      (pos_idx),
        .pos_x        (pos_x),
        .pos_y        (pos_y),
        .busy         (busy),
        .step_done    (step_done)
    );

    typedef struct {
        int idx;
        int x;
        int y;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   mpx [NB], mpy [NB], mvx [NB], mvy [NB];
    int   ax_tab [NB], ay_tab [NB];
    int   got_x [NB], got_y [NB];
    exp_t sb [$];

    task automatic check(input string tag, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int sat16(input int v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    function automatic int rand_q15();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    // Body b absorbs force (ax, ay) for one dt = 1/16; returns the new position.
    task automatic model_xfer(input int b, input int ax, input int ay, output exp_t e);
        mvx[b] = sat16(mvx[b] + (ax >>> DTS));
        mvy[b] = sat16(mvy[b] + (ay >>> DTS));
        mpx[b] = sat16(mpx[b] + (mvx[b] >>> DTS));
        mpy[b] = sat16(mpy[b] + (mvy[b] >>> DTS));
        e.idx = b;
        e.x   = mpx[b];
        e.y   = mpy[b];
    endtask

    task automatic model_clear();
        for (int i = 0; i < NB; i++) begin
            mpx[i] = 0; mpy[i] = 0; mvx[i] = 0; mvy[i] = 0;
        end
        sb.delete();
    endtask

    task automatic clear_tabs();
        for (int i = 0; i < NB; i++) begin
            ax_tab[i] = 0; ay_tab[i] = 0;
        end
    endtask

    task automatic random_tabs();
        for (int i = 0; i < NB; i++) begin
            ax_tab[i] = $signed($urandom) >>> 4;
            ay_tab[i] = $signed($urandom) >>> 4;
        end
    endtask

    task automatic idle_inputs();
        load_en      = 1'b0;
        load_idx     = '0;
        load_x       = '0;
        load_y       = '0;
        load_vx      = '0;
        load_vy      = '0;
        step_start   = 1'b0;
        acc_in_valid = 1'b0;
        acc_in_x     = '0;
        acc_in_y     = '0;
        pos_ready    = 1'b0;
    endtask

    // Called and returns one time unit after a rising edge, block in IDLE.
    task automatic load_body(input int idx, input int x, input int y, input int vx, input int vy);
        load_en  = 1'b1;
        load_idx = IW'(idx);
        load_x   = DW'(x);
        load_y   = DW'(y);
        load_vx  = DW'(vx);
        load_vy  = DW'(vy);
        @(posedge clk); #1;
        load_en  = 1'b0;
        mpx[idx] = x; mpy[idx] = y; mvx[idx] = vx; mvy[idx] = vy;
    endtask

    task automatic run_step(input int valid_pct, input int ready_pct, input bit noise,
                            input int abort_after, input int hold_at);
        int            sent      = 0;
        int            cyc       = 0;
        int            hold_left = 0;
        bit            hold_used = 1'b0;
        bit            in_step   = 1'b0;
        bit            done_flag = 1'b0;
        bit            finished  = 1'b0;
        bit            start_now = 1'b1;
        bit            prev_stall = 1'b0;
        bit            next_in, next_done, exp_pv, exp_rdy;
        logic [IW-1:0] prev_idx;
        logic [DW-1:0] prev_x, prev_y;
        exp_t          e;

        while (!finished && cyc < 2000) begin
            cyc++;
            step_start = start_now;
            start_now  = 1'b0;
            load_en    = 1'b0;
            if (noise && in_step) begin
                step_start = ($urandom_range(0, 7) == 0);
                load_en    = ($urandom_range(0, 3) == 0);
                load_idx   = IW'($urandom);
                load_x     = DW'($urandom);
                load_y     = DW'($urandom);
                load_vx    = DW'($urandom);
                load_vy    = DW'($urandom);
            end
            if (hold_at >= 0 && !hold_used && sent == hold_at + 1) begin
                hold_left = 5;
                hold_used = 1'b1;
            end
            acc_in_valid = (hold_left > 0) || ($urandom_range(1, 100) <= valid_pct);
            pos_ready    = (hold_left == 0) && ($urandom_range(1, 100) <= ready_pct);
            if (hold_left > 0) hold_left--;
            acc_in_x = AW'((sent < NB) ? ax_tab[sent] : int'($urandom));
            acc_in_y = AW'((sent < NB) ? ay_tab[sent] : int'($urandom));
            #1;

            exp_pv  = (sb.size() > 0);
            exp_rdy = in_step && (sent < NB) && (!exp_pv || pos_ready);
            check("pos_valid", pos_valid, exp_pv);
            check("busy", busy, in_step);
            check("step_done", step_done, done_flag);
            check("acc_in_ready", acc_in_ready, exp_rdy);
            if (prev_stall) begin
                check("hold_idx", pos_idx, prev_idx);
                check("hold_x", $signed(pos_x), $signed(prev_x));
                check("hold_y", $signed(pos_y), $signed(prev_y));
            end
            prev_stall = pos_valid && !pos_ready;
            prev_idx   = pos_idx;
            prev_x     = pos_x;
            prev_y     = pos_y;

            next_in   = in_step;
            next_done = 1'b0;
            if (exp_pv && pos_ready) begin
                e = sb.pop_front();
                check("pos_idx", pos_idx, e.idx);
                check("pos_x", $signed(pos_x), e.x);
                check("pos_y", $signed(pos_y), e.y);
                got_x[e.idx] = int'($signed(pos_x));
                got_y[e.idx] = int'($signed(pos_y));
                if (sent == NB && sb.size() == 0) begin
                    next_in   = 1'b0;
                    next_done = 1'b1;
                end
            end
            if (acc_in_valid && exp_rdy) begin
                model_xfer(sent, ax_tab[sent], ay_tab[sent], e);
                sb.push_back(e);
                sent++;
            end
            if (step_start && !in_step) next_in = 1'b1;
            if (done_flag) finished = 1'b1;

            @(posedge clk); #1;
            in_step   = next_in;
            done_flag = next_done;
            if (abort_after > 0 && sent == abort_after) finished = 1'b1;
        end
        if (!finished) check("step_timeout", 0, 1);
        idle_inputs();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pos_valid"}, pos_valid, 0);
        check({tag, "_pos_idx"}, pos_idx, 0);
        check({tag, "_pos_x"}, pos_x, 0);
        check({tag, "_pos_y"}, pos_y, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_step_done"}, step_done, 0);
        check({tag, "_acc_in_ready"}, acc_in_ready, 0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        model_clear();
        #12;
        check_reset_outputs("por");
        @(posedge clk); #1;
        rst = 1'b0;

        // Basic update from rest, then a zero-force step exposes stored vx = 256.
        clear_tabs();
        load_body(0, 0, 0, 0, 0);
        ax_tab[0] = 4096;
        run_step(100, 100, 1'b0, 0, -1);
        check("basic_pos_x", got_x[0], 16);
        check("basic_pos_y", got_y[0], 0);
        clear_tabs();
        run_step(70, 70, 1'b0, 0, -1);
        check("basic_vx_carry", got_x[0], 32);

        // Floor and saturation corners, with a 5-cycle output stall mid-step.
        clear_tabs();
        load_body(1, 0, 0, 0, 0);
        load_body(2, 32760, 0, 32700, 0);
        load_body(3, 0, -32760, 0, -32700);
        ax_tab[1] = -1;
        ax_tab[2] = 8000;
        ay_tab[3] = -8000;
        run_step(100, 100, 1'b0, 0, 3);
        check("floor_pos_x", got_x[1], -1);
        check("sat_hi_pos_x", got_x[2], 32767);
        check("sat_lo_pos_y", got_y[3], -32768);

        // Random state, forces and handshake gaps, with ignored control noise.
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < 4; k++) begin
                load_body($urandom_range(0, NB-1), rand_q15(), rand_q15(), rand_q15(), rand_q15());
            end
            random_tabs();
            run_step(60, 60, 1'b1, 0, -1);
        end

        // Abandon a step after 7 bodies with reset.
        random_tabs();
        run_step(80, 80, 1'b0, 7, -1);
        rst = 1'b1;
        #1;
        check_reset_outputs("mid_rst");
        model_clear();
        @(posedge clk); #1;
        check("mid_rst_no_done", step_done, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        clear_tabs();
        load_body(0, 0, 0, 0, 0);
        ax_tab[0] = 4096;
        run_step(90, 90, 1'b0, 0, -1);
        check("post_rst_pos_x", got_x[0], 16);
        check("post_rst_body5_x", got_x[5], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
